// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding instruction fetch, response buffer and redirect handling.
// Optional misaligned-redirect detection is enabled with FETCH_MISALIGN_CHECK_EN.
//
// state  | meaning
// S_REQ  | issuing a read for pc_q (suppressed by a same-cycle redirect)
// S_WAIT | request outstanding, response will be kept
// S_DROP | request outstanding, response belongs to a redirected-away PC
// S_HOLD | fetched word buffered and presented to IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stallF,
  input  logic        i_pc_src,
  input  logic [31:0] i_pc_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instrF,
  output logic [31:0] o_PCF,
  output logic [31:0] o_PCPlus4F,
  output logic        o_instr_valid,
  output logic        o_fetch_wait,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redirect_pc;
  logic        misaligned_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_pc = {i_pc_target[31:2], 2'b00};

  // Sticky until reset so a later aligned redirect cannot hide the event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      misaligned_q <= 1'b0;
    end else if (i_pc_src && (i_pc_target[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end
`else
  assign redirect_pc  = i_pc_target;
  assign misaligned_q = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    o_imem_req = 1'b0;
    case (state_q)
      S_REQ: begin
        o_imem_req = ~i_pc_src;
        if (i_pc_src) begin
          pc_d = redirect_pc;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_pc_src) begin
          pc_d    = redirect_pc;
          // A response landing with the redirect retires the old request.
          state_d = i_imem_rvalid ? S_REQ : S_DROP;
        end else if (i_imem_rvalid) begin
          buf_d   = i_imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        if (i_pc_src) begin
          pc_d = redirect_pc;
        end
        if (i_imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (i_pc_src) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!i_stallF) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign o_instr_valid = (state_q == S_HOLD);
  assign o_fetch_wait  = ~o_instr_valid;
  assign o_instrF      = o_instr_valid ? buf_q : BUBBLE_INSTR;
  assign o_PCF         = pc_q;
  assign o_imem_addr   = pc_q;
  assign o_PCPlus4F    = pc_q + 32'd4;
  assign o_misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stallF;
  logic        i_pc_src;
  logic [31:0] i_pc_target;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instrF;
  logic [31:0] o_PCF;
  logic [31:0] o_PCPlus4F;
  logic        o_instr_valid;
  logic        o_fetch_wait;
  logic        o_misaligned;

  fetch_stage #(.RESET_PC(RST_PC), .BUBBLE_INSTR(BUBBLE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stallF(i_stallF), .i_pc_src(i_pc_src),
    .i_pc_target(i_pc_target), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata), .o_instrF(o_instrF),
    .o_PCF(o_PCF), .o_PCPlus4F(o_PCPlus4F), .o_instr_valid(o_instr_valid),
    .o_fetch_wait(o_fetch_wait), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[24:0], 7'b0};
  endfunction

  // Transaction-level model: fetched word held, request in flight, in-flight response unwanted.
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] m_instr = 32'h0;
  bit          m_valid = 0;
  bit          m_out   = 0;
  bit          m_stale = 0;
  bit          m_mis   = 0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_pc = RST_PC; m_valid = 0; m_out = 0; m_stale = 0; m_mis = 0;
    end else if (i_pc_src) begin
      m_pc = i_pc_target;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (i_pc_target[1:0] != 2'b00) begin
        m_mis = 1;
        m_pc  = i_pc_target & 32'hFFFF_FFFC;
      end
`endif
      m_valid = 0;
      if (m_out) begin
        if (i_imem_rvalid) begin m_out = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else if (m_valid) begin
      if (!i_stallF) begin m_valid = 0; m_pc = m_pc + 32'd4; end
    end else if (m_out) begin
      if (i_imem_rvalid) begin
        m_out = 0;
        if (!m_stale) begin m_valid = 1; m_instr = i_imem_rdata; end
        m_stale = 0;
      end
    end else begin
      m_out = 1;
    end
  end

  always @(negedge i_clk) begin
    #2;
    chk("req",     o_imem_req,    !m_valid && !m_out && !i_pc_src);
    chk("addr",    o_imem_addr,   m_pc);
    chk("pcf",     o_PCF,         m_pc);
    chk("pcplus4", o_PCPlus4F,    m_pc + 32'd4);
    chk("valid",   o_instr_valid, m_valid);
    chk("wait",    o_fetch_wait,  !m_valid);
    chk("instr",   o_instrF,      m_valid ? m_instr : BUBBLE);
    chk("mis",     o_misaligned,  m_mis);
  end

  // Memory responder plus per-cycle stimulus; inputs change on the falling edge.
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic [31:0] mem_addr = 32'h0;
  bit          rst_next = 0;

  task automatic cyc(input bit stall, input bit src, input logic [31:0] tgt);
    @(negedge i_clk);
    i_imem_rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = mem_word(mem_addr);
      end
    end
    i_rst_n     = rst_next;
    i_stallF    = stall;
    i_pc_src    = src;
    i_pc_target = tgt;
    #2;
    if (o_imem_req && i_rst_n) begin
      mem_cnt  = mem_lat;
      mem_addr = o_imem_addr;
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_stallF = 1'b0; i_pc_src = 1'b0; i_pc_target = 32'h0;
    i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;

    cyc(0, 0, 0);
    chk("rst_pcf", o_PCF, 32'h0); chk("rst_valid", o_instr_valid, 0);
    chk("rst_instr", o_instrF, 32'h0); chk("rst_mis", o_misaligned, 0);
    cyc(0, 0, 0);
    rst_next = 1;

    cyc(0, 0, 0);
    chk("first_req", o_imem_req, 1); chk("first_addr", o_imem_addr, 32'h0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("first_valid", o_instr_valid, 1); chk("first_instr", o_instrF, 32'h0050_0093);
    chk("first_pcf", o_PCF, 32'h0); chk("first_pc4", o_PCPlus4F, 32'h4);
    cyc(0, 0, 0);
    chk("second_req", o_imem_req, 1); chk("second_addr", o_imem_addr, 32'h4);
    cyc(0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      chk("stall_valid", o_instr_valid, 1); chk("stall_instr", o_instrF, 32'h0050_0293);
      chk("stall_pcf", o_PCF, 32'h4); chk("stall_noreq", o_imem_req, 0);
    end
    cyc(0, 0, 0);

    mem_lat = 3;
    cyc(0, 0, 0);
    chk("req8_addr", o_imem_addr, 32'h8); chk("req8_req", o_imem_req, 1);
    cyc(0, 1, 32'h40);
    cyc(0, 0, 0);
    chk("drop_valid", o_instr_valid, 0); chk("drop_pcf", o_PCF, 32'h40); chk("drop_noreq", o_imem_req, 0);
    mem_lat = 1;
    cyc(0, 0, 0);
    chk("drop_rsp_valid", o_instr_valid, 0);
    cyc(0, 0, 0);
    chk("req40_req", o_imem_req, 1); chk("req40_addr", o_imem_addr, 32'h40);
    cyc(0, 0, 0);

    cyc(1, 1, 32'h100);
    chk("h40_valid", o_instr_valid, 1); chk("h40_instr", o_instrF, 32'h0050_2093); chk("h40_pcf", o_PCF, 32'h40);
    cyc(0, 0, 0);
    chk("req100_addr", o_imem_addr, 32'h100); chk("req100_valid", o_instr_valid, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC); chk("wrap_pc4", o_PCPlus4F, 32'h0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("wrap_valid", o_instr_valid, 1);
    cyc(0, 1, 32'h20);
    chk("srcreq_noreq", o_imem_req, 0); chk("srcreq_pcf", o_PCF, 32'h0);
    mem_lat = 3;
    cyc(0, 0, 0);
    chk("req20_addr", o_imem_addr, 32'h20); chk("req20_req", o_imem_req, 1);

    rst_next = 0;
    cyc(0, 0, 0);
    chk("midrst_pcf", o_PCF, 32'h0); chk("midrst_valid", o_instr_valid, 0);
    mem_lat = 1;
    cyc(0, 0, 0);
    rst_next = 1;
    cyc(0, 0, 0);
    chk("postrst_addr", o_imem_addr, 32'h0); chk("postrst_valid", o_instr_valid, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("postrst_instr", o_instrF, 32'h0050_0093); chk("postrst_pcf", o_PCF, 32'h0);

    cyc(0, 0, 0);
    chk("req4b_addr", o_imem_addr, 32'h4);
    cyc(0, 1, 32'h200);
    mem_lat = 4;
    cyc(0, 0, 0);
    chk("req200_addr", o_imem_addr, 32'h200); chk("req200_valid", o_instr_valid, 0);
    cyc(0, 1, 32'h300);
    cyc(0, 1, 32'h304);
    cyc(1, 0, 0);
    chk("multi_pcf", o_PCF, 32'h304); chk("multi_noreq", o_imem_req, 0);
    mem_lat = 1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("req304_addr", o_imem_addr, 32'h304); chk("req304_req", o_imem_req, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 32'h102);
    chk("h304_valid", o_instr_valid, 1);
    cyc(0, 0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_addr", o_imem_addr, 32'h100); chk("mis_flag", o_misaligned, 1);
`else
    chk("mis_addr", o_imem_addr, 32'h102); chk("mis_flag", o_misaligned, 0);
`endif
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
